// File: rtl/expr_seq.sv
// expr_seq: recognises digit(op digit)*'=' ASCII expressions and presents one held result per expression
module expr_seq #(parameter int W = 16) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic         res_valid,
  input  logic         res_ready
);
  typedef enum logic [2:0] {IDLE, OPND, OPER, SKIP, DONE} state_t;
  state_t state;
  logic [W-1:0] acc;
  logic op;
  logic [7:0] dv;
  logic [W-1:0] d;
  logic is_dig, is_op, is_eq;
  // codes below '0' wrap to large values, so one compare classifies digits
  assign dv = in_data - 8'h30;
  assign d = W'(dv);
  assign is_dig = dv < 8'd10;
  assign is_op = in_data == 8'h2B || in_data == 8'h2D;
  assign is_eq = in_data == 8'h3D;
  assign in_ready = clr && state != DONE;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      acc <= '0;
      op <= 1'b0;
      res_data <= '0;
      res_err <= 1'b0;
      res_valid <= 1'b0;
    end else if (state == DONE) begin
      if (res_ready) begin
        state <= IDLE;
        res_valid <= 1'b0;
        acc <= '0;
      end
    end else if (in_valid) begin
      if (is_eq) begin
        state <= DONE;
        res_valid <= 1'b1;
        res_err <= state != OPND;
        res_data <= state == OPND ? acc : '0;
      end else case (state)
        IDLE: if (is_dig) begin acc <= d; state <= OPND; end else state <= SKIP;
        OPND: if (is_op) begin op <= in_data == 8'h2D; state <= OPER; end else state <= SKIP;
        OPER: if (is_dig) begin acc <= op ? acc - d : acc + d; state <= OPND; end else state <= SKIP;
        default: state <= SKIP;
      endcase
    end
  end
endmodule

// File: tb/tb_expr_seq.sv
// tb_expr_seq: directed checks of expr_seq at W=16 and W=4 sharing one stimulus stream
module tb_expr_seq;
  logic clk = 1'b0, clr, in_valid, res_ready;
  logic [7:0] in_data;
  logic in_ready, res_err, res_valid;
  logic [15:0] res_data;
  logic in_ready4, res_err4, res_valid4;
  logic [3:0] res_data4;
  int n_cmp = 0, n_bad = 0;

  expr_seq #(.W(16)) dut (.clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready));
  expr_seq #(.W(4)) dut4 (.clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .res_data(res_data4), .res_err(res_err4), .res_valid(res_valid4), .res_ready(res_ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input byte c);
    int t = 0;
    in_data = c;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("send_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sends(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic get(input string tag, input logic [15:0] exp_d, input logic exp_e);
    int t = 0;
    while (!res_valid && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_valid"}, {31'b0, res_valid}, 1);
    chk({tag, "_data"}, {16'b0, res_data}, {16'b0, exp_d});
    chk({tag, "_err"}, {31'b0, res_err}, {31'b0, exp_e});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_drop"}, {31'b0, res_valid}, 0);
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_data = 8'h00;
    #3;
    chk("rst_valid", {31'b0, res_valid}, 0);
    chk("rst_data", {16'b0, res_data}, 0);
    chk("rst_err", {31'b0, res_err}, 0);
    chk("rst_ready", {31'b0, in_ready}, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {31'b0, in_ready}, 1);
    // result accepted on the first DONE cycle: one-cycle valid pulse and in_ready gap
    res_ready = 1'b1;
    sends("3+4-2=");
    chk("t1_valid", {31'b0, res_valid}, 1);
    chk("t1_data", {16'b0, res_data}, 5);
    chk("t1_err", {31'b0, res_err}, 0);
    chk("t1_ready_low", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    chk("t1_pulse_end", {31'b0, res_valid}, 0);
    chk("t1_ready_back", {31'b0, in_ready}, 1);
    res_ready = 1'b0;
    sends("9-9-9=");
    chk("wrap4_a", {28'b0, res_data4}, 7);
    get("wrap16", 16'hFFF7, 1'b0);
    sends("9+9=");
    chk("w4_data", {28'b0, res_data4}, 2);
    chk("w4_err", {31'b0, res_err4}, 0);
    get("w16_18", 16'h0012, 1'b0);
    sends("12+3=");
    get("multi", 16'h0000, 1'b1);
    sends("1=");
    get("recover", 16'h0001, 1'b0);
    sends("=");
    get("eq_only", 16'h0000, 1'b1);
    sends("5+=");
    get("op_eq", 16'h0000, 1'b1);
    sends("+5=");
    get("lead_op", 16'h0000, 1'b1);
    sends("5a=");
    get("bad_chr", 16'h0000, 1'b1);
    // back-pressure: '7' offered while the result of "8=" is held
    sends("8=");
    in_data = 8'h37;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, res_valid}, 1);
      chk("bp_data", {16'b0, res_data}, 8);
      chk("bp_ready", {31'b0, in_ready}, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_drop", {31'b0, res_valid}, 0);
    chk("bp_ready_back", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sends("=");
    get("bp_seven", 16'h0007, 1'b0);
    sends("7=");
    chk("rd_pre", {31'b0, res_valid}, 1);
    #2 clr = 1'b0;
    #1;
    chk("rd_valid", {31'b0, res_valid}, 0);
    chk("rd_data", {16'b0, res_data}, 0);
    chk("rd_ready", {31'b0, in_ready}, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("rd_no_result", {31'b0, res_valid}, 0);
    sends("7+");
    #2 clr = 1'b0;
    #1;
    chk("rm_valid", {31'b0, res_valid}, 0);
    chk("rm_data", {16'b0, res_data}, 0);
    chk("rm_err", {31'b0, res_err}, 0);
    chk("rm_ready", {31'b0, in_ready}, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    sends("2=");
    get("after_rst", 16'h0002, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
